// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its line filter.
//   state_t    : transmitter FSM states
//   FRAME_BITS : bits shifted out after the start bit (8 data, parity, stop)
//   make_frame : builds {stop, odd parity, data}, data bit 0 first out
//   max2       : helper for sizing counters from parameters
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_START,
        SHIFT,
        ACK,
        WAIT_IDLE,
        FAIL
    } state_t;

    localparam int FRAME_BITS = 10;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer plus glitch filter for one raw PS/2 line.
//   clock     : system clock
//   kbd_clr   : asynchronous active-high reset; output returns to 1 (idle bus)
//   line_raw  : asynchronous pin value
//   line_filt : filtered level; changes only once FILTER_LEN samples agree
// FILTER_LEN must be at least 2.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 16
) (
    input  logic clock,
    input  logic kbd_clr,
    input  logic line_raw,
    output logic line_filt
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] window;

    // NOTE: async reset sits in the sensitivity list; every register here is
    // small control state, so all of it is reset to the idle-bus level.
    always_ff @(posedge clock or posedge kbd_clr) begin
        if (kbd_clr) begin
            sync      <= 2'b11;
            window    <= '1;
            line_filt <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make the shift chain move one
            // stage per clock regardless of statement order.
            sync   <= {sync[0], line_raw};
            window <= {window[FILTER_LEN-2:0], sync[1]};
            if (&window) begin
                line_filt <= 1'b1;
            end else if (~|window) begin
                line_filt <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
//   clock, kbd_clr          : system clock, async active-high reset
//   tx_data, tx_valid       : command byte and send request
//   tx_ready                : idle, a request will be accepted
//   tx_done / tx_err        : one-cycle pulses on ACK+idle / NACK or timeout
//   tx_active               : transfer in progress (receiver ignores frames)
//   ps2_clk_in, ps2_dat_in  : raw PS/2 pins
//   ps2_clk_oe, ps2_dat_oe  : open-drain pull-low enables
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int XFER_TIMEOUT   = 200000,
    parameter int FILTER_LEN     = 16
) (
    input  logic       clock,
    input  logic       kbd_clr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       tx_active,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int CNT_MAX = max2(max2(INHIBIT_CYCLES, START_TIMEOUT),
                                  max2(XFER_TIMEOUT, FILTER_LEN));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_IDX = BIT_CNT_W'(FRAME_BITS - 1);

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt;       // per-state: inhibit, RTS, start timeout
    logic [CNT_W-1:0]       xfer_cnt;  // spans SHIFT, ACK and WAIT_IDLE
    logic [FRAME_BITS-1:0]  frame;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   dat_drv;   // registered data pull-low during SHIFT
    logic                   clk_filt, dat_filt, clk_filt_q;
    logic                   clk_fall, xfer_expired, accept, shift_bit;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock     (clock),
        .kbd_clr   (kbd_clr),
        .line_raw  (ps2_clk_in),
        .line_filt (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clock     (clock),
        .kbd_clr   (kbd_clr),
        .line_raw  (ps2_dat_in),
        .line_filt (dat_filt)
    );

    assign clk_fall     = clk_filt_q & ~clk_filt;
    assign xfer_expired = (xfer_cnt == XFER_LAST);

    // Next-state logic. Timeout checks come before edge checks so an edge in
    // the expiry cycle loses.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_d   = state;
        accept    = 1'b0;
        shift_bit = 1'b0;
        tx_done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    accept  = 1'b1;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INHIBIT_LAST) state_d = RTS;
            end
            RTS: begin
                if (cnt == RTS_LAST) state_d = WAIT_START;
            end
            WAIT_START: begin
                if (cnt == START_LAST) begin
                    state_d = FAIL;
                end else if (clk_fall) begin
                    shift_bit = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer_expired) begin
                    state_d = FAIL;
                end else if (clk_fall) begin
                    shift_bit = 1'b1;
                    if (bit_cnt == STOP_IDX) state_d = ACK;
                end
            end
            ACK: begin
                if (xfer_expired) begin
                    state_d = FAIL;
                end else if (clk_fall) begin
                    state_d = dat_filt ? FAIL : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (xfer_expired) begin
                    state_d = FAIL;
                end else if (clk_filt && dat_filt) begin
                    tx_done = 1'b1;
                    state_d = IDLE;
                end
            end
            FAIL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge kbd_clr) begin
        if (kbd_clr) begin
            state      <= IDLE;
            cnt        <= '0;
            xfer_cnt   <= '0;
            frame      <= '0;
            bit_cnt    <= '0;
            dat_drv    <= 1'b0;
            clk_filt_q <= 1'b1;
        end else begin
            state      <= state_d;
            clk_filt_q <= clk_filt;

            if (state_d != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

            // Transfer timer starts at the first device falling edge (entry
            // into SHIFT) and keeps running until the transfer ends.
            if (state inside {SHIFT, ACK, WAIT_IDLE}) begin
                if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + 1'b1;
            end else begin
                xfer_cnt <= '0;
            end

            if (accept) begin
                frame   <= make_frame(tx_data);
                bit_cnt <= '0;
                dat_drv <= 1'b0;
            end else if (shift_bit) begin
                dat_drv <= ~frame[bit_cnt];
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Line drives decode straight from the state register so that reset
    // releases both lines without waiting for a clock edge.
    assign ps2_clk_oe = (state == INHIBIT) || (state == RTS);
    assign ps2_dat_oe = (state == RTS) || (state == WAIT_START) ||
                        ((state == SHIFT) && dat_drv);
    assign tx_ready   = (state == IDLE);
    assign tx_active  = (state != IDLE);
    assign tx_err     = (state == FAIL);

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INHIBIT_CYCLES = 20;
    localparam int FILTER_LEN     = 4;
    localparam int START_TIMEOUT  = 400;
    localparam int XFER_TIMEOUT   = 2000;
    localparam int HALF           = 20;

    logic       clock = 1'b0;
    logic       kbd_clr = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, tx_active;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    logic [1:0] err_oe = 2'b11;
    logic       ready_after = 1'b0;
    logic       pulse_seen = 1'b0;

    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    // Open-drain bus with pull-ups: either side can pull a line low.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT_CYCLES),
        .START_TIMEOUT  (START_TIMEOUT),
        .XFER_TIMEOUT   (XFER_TIMEOUT),
        .FILTER_LEN     (FILTER_LEN)
    ) dut (
        .clock      (clock),
        .kbd_clr    (kbd_clr),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .tx_active  (tx_active),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    // Pulse monitor: counts high cycles of tx_done/tx_err, records line
    // state during an error pulse and tx_ready in the cycle after a pulse.
    always @(negedge clock) begin
        if (pulse_seen) ready_after = tx_ready;
        pulse_seen = tx_done | tx_err;
        if (tx_done) done_cnt++;
        if (tx_err) begin
            err_cnt++;
            err_oe = {ps2_clk_oe, ps2_dat_oe};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
        total_cnt++;
        if (n >= 1000) $display("FAIL ready_wait: tx_ready=%b want 1", tx_ready);
        else pass_cnt++;
        tx_data  = b;
        tx_valid = 1'b1;
        exp_q.push_back(b);
        @(posedge clock);
        @(negedge clock);
        tx_valid = 1'b0;
        total_cnt++;
        if ({tx_ready, tx_active, ps2_clk_oe} !== 3'b011)
            $display("FAIL accept: ready/active/clk_oe=%b want 011", {tx_ready, tx_active, ps2_clk_oe});
        else pass_cnt++;
    endtask

    // Called right after acceptance; returns in the first cycle the clock
    // line is released.
    task automatic watch_inhibit();
        int   n = 0;
        logic last_dat = 1'b1;
        while (ps2_clk_in === 1'b0 && n < 200) begin
            last_dat = ps2_dat_in;
            n++;
            @(negedge clock);
        end
        total_cnt++;
        if (n !== INHIBIT_CYCLES + FILTER_LEN)
            $display("FAIL inhibit_len: clock low %0d cycles want %0d", n, INHIBIT_CYCLES + FILTER_LEN);
        else pass_cnt++;
        total_cnt++;
        if (last_dat !== 1'b0 || ps2_dat_in !== 1'b0)
            $display("FAIL rts_data: data before/at release %b%b want 00", last_dat, ps2_dat_in);
        else pass_cnt++;
    endtask

    // Device model: clocks the frame in, samples on the rising edge and
    // compares against the scoreboard. Optional glitch, busy request or
    // mid-frame reset after a given bit slot.
    task automatic device_frame(input bit do_ack, input int glitch_bit,
                                input int busy_bit, input int reset_bit);
        logic [9:0] got = '0;
        logic [7:0] exp;
        watch_inhibit();
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: no expected byte queued");
            return;
        end
        pass_cnt++;
        exp = exp_q.pop_front();
        repeat (4) @(negedge clock);
        for (int k = 0; k < 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            if (k < 10) got[k] = ps2_dat_in;
            if (k == reset_bit) begin
                kbd_clr = 1'b1;
                #1;
                total_cnt++;
                if ({ps2_clk_oe, ps2_dat_oe, tx_ready, tx_active} !== 4'b0010)
                    $display("FAIL reset_mid: clk_oe/dat_oe/ready/active=%b want 0010",
                             {ps2_clk_oe, ps2_dat_oe, tx_ready, tx_active});
                else pass_cnt++;
                total_cnt++;
                if (got[3:0] !== exp[3:0])
                    $display("FAIL reset_bits: got %h want %h", got[3:0], exp[3:0]);
                else pass_cnt++;
                dev_clk_low = 1'b0;
                repeat (3) @(negedge clock);
                kbd_clr = 1'b0;
                repeat (20) @(negedge clock);
                return;
            end
            if (k == 9 && do_ack) dev_dat_low = 1'b1;
            dev_clk_low = 1'b0;
            if (k == glitch_bit) begin
                repeat (8) @(negedge clock);
                dev_clk_low = 1'b1;
                repeat (2) @(negedge clock);
                dev_clk_low = 1'b0;
                repeat (HALF - 10) @(negedge clock);
            end else if (k == busy_bit) begin
                repeat (5) @(negedge clock);
                tx_data  = ~exp;
                tx_valid = 1'b1;
                total_cnt++;
                if (tx_ready !== 1'b0) $display("FAIL busy_ready: tx_ready=%b want 0", tx_ready);
                else pass_cnt++;
                @(negedge clock);
                tx_valid = 1'b0;
                repeat (HALF - 6) @(negedge clock);
            end else begin
                repeat (HALF) @(negedge clock);
            end
            if (k == 10) dev_dat_low = 1'b0;
        end
        total_cnt++;
        if (got !== {1'b1, ~^exp, exp})
            $display("FAIL frame: stop/parity/data=%b want %b", got, {1'b1, ~^exp, exp});
        else pass_cnt++;
    endtask

    task automatic wait_outcome(input int d0, input int e0);
        int n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 200) begin @(negedge clock); n++; end
        repeat (5) @(negedge clock);
    endtask

    task automatic expect_done(input string name, input int d0, input int e0);
        total_cnt++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
            $display("FAIL %s_done: done=%0d err=%0d want 1 0", name, done_cnt - d0, err_cnt - e0);
        else pass_cnt++;
        total_cnt++;
        if (tx_ready !== 1'b1 || ready_after !== 1'b1)
            $display("FAIL %s_ready: ready=%b after_pulse=%b want 1 1", name, tx_ready, ready_after);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        total_cnt++;
        if ({tx_ready, tx_done, tx_err, tx_active, ps2_clk_oe, ps2_dat_oe} !== 6'b100000)
            $display("FAIL reset: ready/done/err/active/clk_oe/dat_oe=%b want 100000",
                     {tx_ready, tx_done, tx_err, tx_active, ps2_clk_oe, ps2_dat_oe});
        else pass_cnt++;
        kbd_clr = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_send(input logic [7:0] b, input string name);
        int d0 = done_cnt;
        int e0 = err_cnt;
        ready_after = 1'b0;
        send(b);
        device_frame(1'b1, -1, -1, -1);
        wait_outcome(d0, e0);
        expect_done(name, d0, e0);
    endtask

    task automatic test_nack();
        int d0 = done_cnt;
        int e0 = err_cnt;
        ready_after = 1'b0;
        err_oe = 2'b11;
        send(8'hEE);
        device_frame(1'b0, -1, -1, -1);
        wait_outcome(d0, e0);
        total_cnt++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0)
            $display("FAIL nack_err: err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0);
        else pass_cnt++;
        total_cnt++;
        if (err_oe !== 2'b00 || ready_after !== 1'b1)
            $display("FAIL nack_lines: oe=%b ready_after=%b want 00 1", err_oe, ready_after);
        else pass_cnt++;
    endtask

    task automatic test_no_response();
        int n = 0;
        send(8'hFF);
        watch_inhibit();
        void'(exp_q.pop_front());
        while (tx_err !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
        total_cnt++;
        if (n !== START_TIMEOUT)
            $display("FAIL start_timeout: err after %0d cycles want %0d", n, START_TIMEOUT);
        else pass_cnt++;
        total_cnt++;
        if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00)
            $display("FAIL timeout_lines: oe=%b want 00", {ps2_clk_oe, ps2_dat_oe});
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (tx_ready !== 1'b1 || tx_err !== 1'b0)
            $display("FAIL timeout_ready: ready=%b err=%b want 1 0", tx_ready, tx_err);
        else pass_cnt++;
    endtask

    task automatic test_mid_frame_reset();
        send(8'hED);
        device_frame(1'b1, -1, -1, 3);
        test_send(8'hFF, "after_reset");
    endtask

    task automatic test_busy_glitch();
        int d0 = done_cnt;
        int e0 = err_cnt;
        ready_after = 1'b0;
        send(8'hA5);
        device_frame(1'b1, 2, 4, -1);
        wait_outcome(d0, e0);
        expect_done("busy_glitch", d0, e0);
    endtask

    initial begin
        test_reset();
        test_send(8'hED, "send_ed");
        test_send(8'hF4, "send_f4");
        test_nack();
        test_no_response();
        test_mid_frame_reset();
        test_busy_glitch();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_left: %0d entries want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
